multicycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. It succeeds the single-cycle combinational decoder. It sequences fetch, decode, execute, memory and writeback over several clocks against a shared instruction/data memory with a ready handshake. It decodes all RV32I base opcodes and detects illegal instructions and memory timeouts. It sits between the instruction register and the datapath muxes, register file, PC register and memory port.

---
 rtl/multicycle_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] against a shared
// instruction/data memory with a ready handshake. Decodes all RV32I base opcodes, halts on
// illegal opcodes, ECALL/EBREAK and memory timeouts.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr               instruction register contents (valid from DECODE onward)
//   mem_ready           memory completes the current request this cycle
//   branch_taken        datapath comparator result for the current branch
//   mem_req/mem_we      memory request / store qualifier
//   mem_addr_sel        0 = PC, 1 = ALU result
//   ir_write, pc_write  instruction register / PC enables
//   pc_src              0 = PC+4, 1 = ALU, 2 = ALU & ~1
//   alu_control         {alt, func3}
//   alu_src_a_sel       0 = rs1, 1 = old_pc, 2 = zero
//   alu_src_b_sel       0 = rs2, 1 = immediate, 2 = constant 4
//   imm_sel             0 = I, 1 = S, 2 = B, 3 = U, 4 = J
//   reg_write, wb_sel   register write enable / 0 = ALU, 1 = load data, 2 = PC
//   halted, illegal, timeout, state   status and debug
module multicycle_controller #(
    parameter int unsigned ALU_CTRL_W   = 4,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addr_sel,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            alu_src_a_sel,
    output logic [1:0]            alu_src_b_sel,
    output logic [2:0]            imm_sel,
    output logic                  reg_write,
    output logic [1:0]            wb_sel,
    output logic                  halted,
    output logic                  illegal,
    output logic                  timeout,
    output logic [2:0]            state
);

    localparam int unsigned CntW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(WAIT_TIMEOUT);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       rd_nz;
    logic [3:0] alu_code;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign func3        = instr[14:12];
    assign rd_nz        = (instr[11:7] != 5'd0);
    assign unused_instr = ^{instr[31], instr[29:15]};
    assign alu_control  = ALU_CTRL_W'(alu_code);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        alu_code      = 4'd0;
        alu_src_a_sel = 2'd0;
        alu_src_b_sel = 2'd0;
        imm_sel       = 3'd0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        halted        = 1'b0;

        // ALU controls stay valid from EXECUTE through MEMORY/WRITEBACK.
        if (state_q inside {StExecute, StMemory, StWriteback}) begin
            unique case (opcode)
                OpcOp:     alu_code = {instr[30], func3};
                OpcOpImm: begin
                    alu_code      = {(func3 == 3'b101) & instr[30], func3};
                    alu_src_b_sel = 2'd1;
                end
                OpcLoad:   alu_src_b_sel = 2'd1;
                OpcStore: begin
                    alu_src_b_sel = 2'd1;
                    imm_sel       = 3'd1;
                end
                OpcBranch: begin
                    alu_src_a_sel = 2'd1;
                    alu_src_b_sel = 2'd1;
                    imm_sel       = 3'd2;
                end
                OpcLui: begin
                    alu_src_a_sel = 2'd2;
                    alu_src_b_sel = 2'd1;
                    imm_sel       = 3'd3;
                end
                OpcAuipc: begin
                    alu_src_a_sel = 2'd1;
                    alu_src_b_sel = 2'd1;
                    imm_sel       = 3'd3;
                end
                OpcJal: begin
                    alu_src_a_sel = 2'd1;
                    alu_src_b_sel = 2'd1;
                    imm_sel       = 3'd4;
                end
                OpcJalr:   alu_src_b_sel = 2'd1;
                default: ;
            endcase
        end

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (opcode inside {OpcOp, OpcOpImm, OpcLoad, OpcStore, OpcBranch, OpcLui,
                                   OpcAuipc, OpcJal, OpcJalr, OpcFence, OpcSystem}) begin
                    state_d = StExecute;
                end else begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
            end
            StExecute: begin
                unique case (opcode)
                    OpcOp, OpcOpImm, OpcLui, OpcAuipc: state_d = StWriteback;
                    OpcLoad, OpcStore:                 state_d = StMemory;
                    OpcBranch: begin
                        pc_src   = 2'd1;
                        pc_write = branch_taken;
                        state_d  = StFetch;
                    end
                    OpcJal, OpcJalr: begin
                        pc_src    = (opcode == OpcJal) ? 2'd1 : 2'd2;
                        pc_write  = 1'b1;
                        reg_write = rd_nz;
                        wb_sel    = 2'd2;
                        state_d   = StFetch;
                    end
                    OpcFence:  state_d = StFetch;
                    OpcSystem: state_d = StHalt;
                    default: begin
                        // instr changed after DECODE; treat as illegal.
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemory: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OpcStore);
                if (mem_ready) begin
                    state_d = (opcode == OpcStore) ? StFetch : StWriteback;
                end
            end
            StWriteback: begin
                reg_write = rd_nz;
                wb_sel    = (opcode == OpcLoad) ? 2'd1 : 2'd0;
                state_d   = StFetch;
            end
            StHalt:  halted = 1'b1;
            default: state_d = StHalt;
        endcase

        // Shared wait counter for FETCH and MEMORY requests.
        if (mem_req) begin
            if (mem_ready) begin
                wait_cnt_d = '0;
            end else if ((WAIT_TIMEOUT != 0) && (wait_cnt_q == TimeoutVal)) begin
                wait_cnt_d = '0;
                state_d    = StHalt;
                timeout_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        illegal = illegal_q;
        timeout = timeout_q;
        state   = state_q;

        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr_sel  = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 2'd0;
            alu_code      = 4'd0;
            alu_src_a_sel = 2'd0;
            alu_src_b_sel = 2'd0;
            imm_sel       = 3'd0;
            reg_write     = 1'b0;
            wb_sel        = 2'd0;
            halted        = 1'b0;
            illegal       = 1'b0;
            timeout       = 1'b0;
            state         = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       as;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic [3:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic       rw;
        logic [1:0] wb;
        logic       h;
        logic       il;
        logic       to;
    } outs_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] instr;
        logic        rdy;
        logic        br;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SRAI  = 32'h4032D293;
    localparam logic [31:0] I_SUB   = 32'h40208133;
    localparam logic [31:0] I_ADDIN = 32'hC0000093;  // addi x1,x0,-1024 (instr[30]=1)
    localparam logic [31:0] I_LW    = 32'h0080A203;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_JAL1  = 32'h010000EF;
    localparam logic [31:0] I_JAL0  = 32'h0100006F;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_AUIPC = 32'h00001017;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_control;
    logic [1:0]  alu_src_a_sel, alu_src_b_sel;
    logic [2:0]  imm_sel;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        halted, illegal, timeout;
    logic [2:0]  state;
    outs_t       act;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    multicycle_controller #(
        .ALU_CTRL_W  (4),
        .WAIT_TIMEOUT(15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_control  (alu_control),
        .alu_src_a_sel(alu_src_a_sel),
        .alu_src_b_sel(alu_src_b_sel),
        .imm_sel      (imm_sel),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .illegal      (illegal),
        .timeout      (timeout),
        .state        (state)
    );

    assign act = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_control,
                  alu_src_a_sel, alu_src_b_sel, imm_sel, reg_write, wb_sel, halted, illegal,
                  timeout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t o(input logic [2:0] st, input logic req, input logic we,
                                input logic as, input logic irw, input logic pcw,
                                input logic [1:0] pcs, input logic [3:0] alu,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [2:0] imm, input logic rw, input logic [1:0] wb,
                                input logic h, input logic il, input logic to);
        outs_t r;
        r.st  = st;  r.req = req; r.we  = we;  r.as  = as;  r.irw = irw; r.pcw = pcw;
        r.pcs = pcs; r.alu = alu; r.sa  = sa;  r.sb  = sb;  r.imm = imm; r.rw  = rw;
        r.wb  = wb;  r.h   = h;   r.il  = il;  r.to  = to;
        return r;
    endfunction

    task automatic add(input string name, input logic r, input logic [31:0] ins,
                       input logic rdy, input logic br, input outs_t exp);
        vec_t v;
        v.name = name; v.rst = r; v.instr = ins; v.rdy = rdy; v.br = br; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Drive inputs at the falling edge, compare 1ns later, state advances on the next rise.
    task automatic cyc(input string name, input logic r, input logic [31:0] ins,
                       input logic rdy, input logic br, input outs_t exp);
        @(negedge clk);
        rst          = r;
        instr        = ins;
        mem_ready    = rdy;
        branch_taken = br;
        #1;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    outs_t zero, fet, fwait, dec, hlt_il, hlt_to;

    initial begin
        rst          = 1'b1;
        instr        = I_ADD;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;

        zero   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fet    = o(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwait  = o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec    = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hlt_il = o(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        hlt_to = o(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        add("rst",      1, I_ADD, 1, 0, zero);
        add("add_f",    0, I_ADD, 1, 0, fet);
        add("add_d",    0, I_ADD, 1, 0, dec);
        add("add_e",    0, I_ADD, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("add_w",    0, I_ADD, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        add("srai_f",   0, I_SRAI, 1, 0, fet);
        add("srai_d",   0, I_SRAI, 1, 0, dec);
        add("srai_e",   0, I_SRAI, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 4'hD, 0, 1, 0, 0, 0, 0, 0, 0));
        add("srai_w",   0, I_SRAI, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 4'hD, 0, 1, 0, 1, 0, 0, 0, 0));
        add("sub_f",    0, I_SUB, 1, 0, fet);
        add("sub_d",    0, I_SUB, 1, 0, dec);
        add("sub_e",    0, I_SUB, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sub_w",    0, I_SUB, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 4'h8, 0, 0, 0, 1, 0, 0, 0, 0));
        add("addin_f",  0, I_ADDIN, 1, 0, fet);
        add("addin_d",  0, I_ADDIN, 1, 0, dec);
        add("addin_e",  0, I_ADDIN, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("addin_w",  0, I_ADDIN, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 1, 0, 0, 0, 0));
        add("lw_f",     0, I_LW, 1, 0, fet);
        add("lw_d",     0, I_LW, 1, 0, dec);
        add("lw_e",     0, I_LW, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("lw_m0",    0, I_LW, 0, 0, o(3, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("lw_m1",    0, I_LW, 0, 0, o(3, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("lw_m2",    0, I_LW, 0, 0, o(3, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("lw_m3",    0, I_LW, 1, 0, o(3, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("lw_w",     0, I_LW, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        add("sw_f",     0, I_SW, 1, 0, fet);
        add("sw_d",     0, I_SW, 1, 0, dec);
        add("sw_e",     0, I_SW, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        add("sw_m",     0, I_SW, 1, 0, o(3, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        add("beq0_f",   0, I_BEQ, 1, 0, fet);
        add("beq0_d",   0, I_BEQ, 1, 0, dec);
        add("beq0_e",   0, I_BEQ, 1, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        add("beq1_f",   0, I_BEQ, 1, 1, fet);
        add("beq1_d",   0, I_BEQ, 1, 1, dec);
        add("beq1_e",   0, I_BEQ, 1, 1, o(2, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        add("jal1_f",   0, I_JAL1, 1, 0, fet);
        add("jal1_d",   0, I_JAL1, 1, 0, dec);
        add("jal1_e",   0, I_JAL1, 1, 0, o(2, 0, 0, 0, 0, 1, 1, 0, 1, 1, 4, 1, 2, 0, 0, 0));
        add("jal0_f",   0, I_JAL0, 1, 0, fet);
        add("jal0_d",   0, I_JAL0, 1, 0, dec);
        add("jal0_e",   0, I_JAL0, 1, 0, o(2, 0, 0, 0, 0, 1, 1, 0, 1, 1, 4, 0, 2, 0, 0, 0));
        add("jalr_f",   0, I_JALR, 1, 0, fet);
        add("jalr_d",   0, I_JALR, 1, 0, dec);
        add("jalr_e",   0, I_JALR, 1, 0, o(2, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 1, 2, 0, 0, 0));
        add("lui_f",    0, I_LUI, 1, 0, fet);
        add("lui_d",    0, I_LUI, 1, 0, dec);
        add("lui_e",    0, I_LUI, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 0));
        add("lui_w",    0, I_LUI, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 1, 0, 0, 0, 0));
        add("auipc_f",  0, I_AUIPC, 1, 0, fet);
        add("auipc_d",  0, I_AUIPC, 1, 0, dec);
        add("auipc_e",  0, I_AUIPC, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0));
        add("auipc_w0", 0, I_AUIPC, 1, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0));
        add("fence_f",  0, I_FENCE, 1, 0, fet);
        add("fence_d",  0, I_FENCE, 1, 0, dec);
        add("fence_e",  0, I_FENCE, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ecall_fw", 0, I_ECALL, 0, 0, fwait);
        add("ecall_f",  0, I_ECALL, 1, 0, fet);
        add("ecall_d",  0, I_ECALL, 1, 0, dec);
        add("ecall_e",  0, I_ECALL, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ecall_h",  0, I_ECALL, 1, 1, o(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add("rst2",     1, I_ECALL, 1, 0, zero);
        add("bad_f",    0, I_BAD, 1, 0, fet);
        add("bad_d",    0, I_BAD, 1, 0, dec);
        add("bad_h",    0, I_BAD, 1, 0, hlt_il);

        foreach (tbl[i]) cyc(tbl[i].name, tbl[i].rst, tbl[i].instr, tbl[i].rdy, tbl[i].br,
                             tbl[i].exp);

        // Illegal halt is sticky and strobe-free whatever the inputs do.
        for (int i = 0; i < 20; i++) begin
            cyc("halt_hold", 0, (i % 2 == 0) ? I_ADD : I_JAL1, i[0], i[1], hlt_il);
        end
        cyc("halt_rst", 1, I_FENCE, 0, 0, zero);
        cyc("halt_clr", 0, I_FENCE, 0, 0, fwait);

        // Boundary: 15 wait cycles then ready still completes the fetch.
        cyc("tb_rst", 1, I_FENCE, 0, 0, zero);
        for (int i = 0; i < 15; i++) cyc("to15_wait", 0, I_FENCE, 0, 0, fwait);
        cyc("to15_done", 0, I_FENCE, 1, 0, fet);
        cyc("to15_dec", 0, I_FENCE, 1, 0, dec);

        // 16 cycles without ready: halts with timeout; late ready changes nothing.
        cyc("to_rst", 1, I_FENCE, 0, 0, zero);
        for (int i = 0; i < 16; i++) cyc("to16_wait", 0, I_FENCE, 0, 0, fwait);
        cyc("to_halt", 0, I_FENCE, 1, 0, hlt_to);
        cyc("to_hold", 0, I_FENCE, 1, 0, hlt_to);
        cyc("to_rst2", 1, I_FENCE, 0, 0, zero);
        cyc("to_clr", 0, I_FENCE, 0, 0, fwait);

        // Reset in the middle of a load's MEMORY wait.
        cyc("mr_rst", 1, I_LW, 1, 0, zero);
        cyc("mr_f", 0, I_LW, 1, 0, fet);
        cyc("mr_d", 0, I_LW, 1, 0, dec);
        cyc("mr_e", 0, I_LW, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc("mr_m0", 0, I_LW, 0, 0, o(3, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc("mr_rstcyc", 1, I_LW, 0, 0, zero);
        cyc("mr_after", 0, I_LW, 0, 0, fwait);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
